// File: rtl/uart_rx_frame_ctrl_if.sv
// Bundle between the UART frame controller and its byte source / frame consumer.
// Latency: none, wires only.
// Backpressure: frame_valid/frame_ack handshake; the byte stream itself cannot be stalled.
interface uart_rx_frame_ctrl_if #(
  parameter int MAX_LEN = 16
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(MAX_LEN);

  logic [7:0]    rx_data;
  logic          donerx;
  logic          frame_valid;
  logic [LW-1:0] frame_len;
  logic          frame_ack;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          err_len;
  logic          err_csum;
  logic          err_timeout;
  logic          overrun;

  // Byte source and frame consumer side
  modport master (
    output rx_data, donerx, frame_ack, rd_addr,
    input  frame_valid, frame_len, rd_data, err_len, err_csum, err_timeout, overrun
  );

  // Frame controller side
  modport slave (
    input  rx_data, donerx, frame_ack, rd_addr,
    output frame_valid, frame_len, rd_data, err_len, err_csum, err_timeout, overrun
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Frames the UART byte stream as SOF, LEN, payload, checksum; holds good frames for a consumer.
// Latency: state/flags update 1 cycle after a byte strobe; rd_data is 1 cycle after rd_addr.
// Backpressure: a held frame blocks reception; bytes arriving then are dropped and flagged as overrun.
module uart_rx_frame_ctrl #(
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] SOF     = 8'hA5,
  parameter int         TIMEOUT = 20000
) (
  input logic               clk,
  input logic               rst,
  uart_rx_frame_ctrl_if.slave bus
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    MAX_B    = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_HOLD
  } state_t;

  state_t        state;
  state_t        nstate;
  logic          donerx_q;
  logic          byte_stb;
  logic [LW-1:0] len_q;
  logic [LW-1:0] idx;
  logic [7:0]    csum;
  logic [TW-1:0] tcnt;
  logic [LW-1:0] flen_q;
  logic [7:0]    rd_q;
  logic          err_len_q;
  logic          err_csum_q;
  logic          err_tmo_q;
  logic          ovr_q;
  logic [7:0]    buffer [MAX_LEN];

  logic in_frame;
  logic tmo;
  logic do_len;
  logic do_pay;
  logic do_done;
  logic p_elen;
  logic p_ecsum;
  logic p_etmo;
  logic p_ovr;

  // The receiver may hold donerx for many cycles; only its rising edge counts as a byte.
  assign byte_stb = bus.donerx & ~donerx_q;

  // Next-state and per-byte control decode
  always_comb begin
    nstate   = state;
    do_len   = 1'b0;
    do_pay   = 1'b0;
    do_done  = 1'b0;
    p_elen   = 1'b0;
    p_ecsum  = 1'b0;
    p_etmo   = 1'b0;
    p_ovr    = 1'b0;
    in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
    // A strobe landing on the expiry cycle still wins, hence the !byte_stb term.
    tmo      = in_frame && !byte_stb && (tcnt == TMO_LAST);
    case (state)
      S_IDLE: begin
        if (byte_stb && bus.rx_data == SOF) nstate = S_LEN;
      end
      S_LEN: begin
        if (byte_stb) begin
          if (bus.rx_data == 8'h00 || bus.rx_data > MAX_B) begin
            p_elen = 1'b1;
            nstate = S_IDLE;
          end else begin
            do_len = 1'b1;
            nstate = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (byte_stb) begin
          do_pay = 1'b1;
          if (idx == len_q - LW'(1)) nstate = S_CSUM;
        end
      end
      S_CSUM: begin
        if (byte_stb) begin
          if (bus.rx_data == csum) begin
            do_done = 1'b1;
            nstate  = S_HOLD;
          end else begin
            p_ecsum = 1'b1;
            nstate  = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        // An ack releases the frame and the same-cycle byte is judged as if already idle.
        if (bus.frame_ack) begin
          nstate = (byte_stb && bus.rx_data == SOF) ? S_LEN : S_IDLE;
        end else if (byte_stb) begin
          p_ovr = 1'b1;
        end
      end
      default: nstate = S_IDLE;
    endcase
    if (tmo) begin
      p_etmo = 1'b1;
      nstate = S_IDLE;
    end
  end

  // State, framing datapath, inter-byte timer and registered output pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      donerx_q   <= 1'b0;
      len_q      <= '0;
      idx        <= '0;
      csum       <= 8'h00;
      tcnt       <= '0;
      flen_q     <= '0;
      err_len_q  <= 1'b0;
      err_csum_q <= 1'b0;
      err_tmo_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state      <= nstate;
      donerx_q   <= bus.donerx;
      err_len_q  <= p_elen;
      err_csum_q <= p_ecsum;
      err_tmo_q  <= p_etmo;
      ovr_q      <= p_ovr;
      if (do_len) begin
        len_q <= LW'(bus.rx_data);
        csum  <= bus.rx_data;
        idx   <= '0;
      end
      if (do_pay) begin
        csum <= csum + bus.rx_data;
        idx  <= idx + LW'(1);
      end
      if (do_done) flen_q <= len_q;
      if (byte_stb || !in_frame) tcnt <= '0;
      else                       tcnt <= tcnt + TW'(1);
    end
  end

  // Payload storage; no reset so it maps onto plain registers, only meaningful while a frame is held
  always_ff @(posedge clk) begin
    if (do_pay) buffer[idx[AW-1:0]] <= bus.rx_data;
  end

  // Registered random-access read port
  always_ff @(posedge clk) begin
    if (rst) rd_q <= 8'h00;
    else if (32'(bus.rd_addr) < MAX_LEN) rd_q <= buffer[bus.rd_addr];
    else rd_q <= 8'h00;
  end

  assign bus.frame_valid = (state == S_HOLD);
  assign bus.frame_len   = flen_q;
  assign bus.rd_data     = rd_q;
  assign bus.err_len     = err_len_q;
  assign bus.err_csum    = err_csum_q;
  assign bus.err_timeout = err_tmo_q;
  assign bus.overrun     = ovr_q;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed byte streams, expected events queued by stimulus.
// Latency: events are expected in the cycle computed from the strobe edge that causes them.
// Backpressure: frame release is driven by the bench through frame_ack.
module tb_uart_rx_frame_ctrl;
  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 200;
  localparam int GAP     = 2;
  localparam int AW      = $clog2(MAX_LEN);

  localparam int EV_NONE  = 0;
  localparam int EV_FRAME = 1;
  localparam int EV_FFALL = 2;
  localparam int EV_ELEN  = 3;
  localparam int EV_ECSUM = 4;
  localparam int EV_ETMO  = 5;
  localparam int EV_OVR   = 6;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_frame_ctrl_if #(.MAX_LEN(MAX_LEN)) bus ();

  uart_rx_frame_ctrl #(
    .MAX_LEN(MAX_LEN),
    .SOF    (8'hA5),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t        expq [$];
  logic [7:0] rdq  [$];
  logic       rd_req   = 1'b0;
  logic       rd_req_q = 1'b0;
  bit         fv_prev  = 1'b0;
  int         n_chk    = 0;
  int         n_fail   = 0;
  int         hold_cur = 1;
  int         sc;

  always @(posedge clk) rd_req_q <= rd_req;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic observe(input int kind, input int val);
    ev_t e;
    n_chk++;
    if (expq.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d cyc=%0d expected none", kind, val, cyc);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event: got kind=%0d val=%0d cyc=%0d expected kind=%0d val=%0d cyc=%0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  // Monitor: turns DUT outputs into events and checks them against the queues
  always @(negedge clk) begin
    if (rst) begin
      fv_prev = 1'b0;
    end else begin
      if (bus.frame_valid && !fv_prev) observe(EV_FRAME, int'(bus.frame_len));
      if (!bus.frame_valid && fv_prev) observe(EV_FFALL, 0);
      if (bus.err_len)     observe(EV_ELEN, 0);
      if (bus.err_csum)    observe(EV_ECSUM, 0);
      if (bus.err_timeout) observe(EV_ETMO, 0);
      if (bus.overrun)     observe(EV_OVR, 0);
      fv_prev = bus.frame_valid;
      if (rd_req_q) begin
        n_chk++;
        if (rdq.size() == 0) begin
          n_fail++;
          $display("FAIL rd_data: got %0h with no read expected", bus.rd_data);
        end else begin
          logic [7:0] e;
          e = rdq.pop_front();
          if (bus.rd_data !== e) begin
            n_fail++;
            $display("FAIL rd_data: got %0h expected %0h", bus.rd_data, e);
          end
        end
      end
    end
  end

  // One receiver byte: donerx high for hold cycles, then low for GAP cycles
  task automatic send_byte(input logic [7:0] b, input int hold, input int kind, input int val,
                           input bit ack, output int stb_cyc);
    bus.rx_data = b;
    bus.donerx  = 1'b1;
    if (ack) bus.frame_ack = 1'b1;
    @(posedge clk); #1;
    stb_cyc       = cyc;
    bus.frame_ack = 1'b0;
    if (kind != EV_NONE) expq.push_back(ev_t'{kind, val, cyc});
    repeat (hold - 1) begin @(posedge clk); #1; end
    bus.donerx = 1'b0;
    repeat (GAP) begin @(posedge clk); #1; end
  endtask

  task automatic sb(input logic [7:0] b, input int kind = EV_NONE, input int val = 0);
    int s;
    send_byte(b, hold_cur, kind, val, 1'b0, s);
  endtask

  task automatic rd(input int a, input logic [7:0] e);
    bus.rd_addr = AW'(a);
    rdq.push_back(e);
    rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic ack();
    bus.frame_ack = 1'b1;
    @(posedge clk); #1;
    bus.frame_ack = 1'b0;
    expq.push_back(ev_t'{EV_FFALL, 0, cyc});
    @(posedge clk); #1;
  endtask

  initial begin
    bus.rx_data   = 8'h00;
    bus.donerx    = 1'b0;
    bus.frame_ack = 1'b0;
    bus.rd_addr   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_frame_valid", int'(bus.frame_valid), 0);
    chk("rst_frame_len",   int'(bus.frame_len),   0);
    chk("rst_rd_data",     int'(bus.rd_data),     0);
    chk("rst_err_len",     int'(bus.err_len),     0);
    chk("rst_err_csum",    int'(bus.err_csum),    0);
    chk("rst_err_timeout", int'(bus.err_timeout), 0);
    chk("rst_overrun",     int'(bus.overrun),     0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Good frame, read back, release
    sb(8'hA5); sb(8'h03); sb(8'h11); sb(8'h22); sb(8'h33); sb(8'h69, EV_FRAME, 3);
    rd(0, 8'h11); rd(1, 8'h22); rd(2, 8'h33);
    ack();

    // Checksum error, then a good frame is still accepted
    sb(8'hA5); sb(8'h02); sb(8'h10); sb(8'h20); sb(8'h33, EV_ECSUM);
    sb(8'hA5); sb(8'h01); sb(8'h7F); sb(8'h80, EV_FRAME, 1);
    rd(0, 8'h7F);
    ack();

    // Length errors; trailing bytes are ignored while idle
    sb(8'hA5); sb(8'h00, EV_ELEN); sb(8'h01); sb(8'h10); sb(8'h11);
    sb(8'hA5); sb(8'h11, EV_ELEN); sb(8'h22); sb(8'h01);

    // Inter-byte timeout, late bytes do not form a frame
    sb(8'hA5); sb(8'h02);
    send_byte(8'h10, 1, EV_NONE, 0, 1'b0, sc);
    expq.push_back(ev_t'{EV_ETMO, 0, sc + TIMEOUT});
    repeat (TIMEOUT + 5) begin @(posedge clk); #1; end
    sb(8'h20); sb(8'h32);

    // Overrun while held, buffer unchanged, then ack together with SOF
    sb(8'hA5); sb(8'h02); sb(8'hAB); sb(8'hCD); sb(8'h7A, EV_FRAME, 2);
    sb(8'h55, EV_OVR);
    rd(0, 8'hAB); rd(1, 8'hCD);
    send_byte(8'hA5, 1, EV_FFALL, 0, 1'b1, sc);
    sb(8'h01); sb(8'h5A); sb(8'h5B, EV_FRAME, 1);
    rd(0, 8'h5A);
    ack();

    // Long donerx: one byte per assertion
    hold_cur = 50;
    sb(8'hA5); sb(8'h02); sb(8'h01); sb(8'h02); sb(8'h05, EV_FRAME, 2);
    hold_cur = 1;
    rd(0, 8'h01); rd(1, 8'h02);
    ack();

    // Reset in the middle of a payload
    bus.rd_addr = '0;
    sb(8'hA5); sb(8'h04); sb(8'h11);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_frame_valid", int'(bus.frame_valid), 0);
    chk("midrst_frame_len",   int'(bus.frame_len),   0);
    chk("midrst_rd_data",     int'(bus.rd_data),     0);
    chk("midrst_err_timeout", int'(bus.err_timeout), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    sb(8'hA5); sb(8'h01); sb(8'h42); sb(8'h43, EV_FRAME, 1);
    rd(0, 8'h42);
    ack();

    repeat (5) begin @(posedge clk); #1; end
    chk("pending_events", expq.size(), 0);
    chk("pending_reads",  rdq.size(),  0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Frame controller that sits directly behind the UART receiver. It turns the receiver's byte stream (`rx_data`/`donerx`) into validated frames of the form SOF, LEN, payload, checksum. Payload bytes are buffered internally, and a complete frame is presented to a downstream consumer through a valid/ack handshake plus a random-access read port. Malformed, corrupted and stalled frames are discarded, and each is reported on an error strobe.

## Interface
Parameters:
- `MAX_LEN`, 16: maximum payload bytes per frame (2..255); also the depth of the payload buffer.
- `SOF`, 8'hA5: start-of-frame byte value.
- `TIMEOUT`, 20000: maximum `clk` cycles allowed between consecutive bytes inside a frame.

Ports:
- `clk` input 1: system clock, the same clock that drives the UART receiver.
- `rst` input 1: synchronous, active-high reset.
- `rx_data` input 8: received byte from the UART receiver.
- `donerx` input 1: byte-done flag from the receiver. It is high for one or more `clk` cycles per byte and is synchronous to `clk`.
- `frame_valid` output 1: a complete, checksum-good frame is held in the buffer.
- `frame_len` output $clog2(MAX_LEN+1): payload length of the held frame.
- `frame_ack` input 1: consumer has finished with the frame; sampled only while `frame_valid` is high.
- `rd_addr` input $clog2(MAX_LEN): payload byte index.
- `rd_data` output 8: buffer[`rd_addr`], registered with 1-cycle latency.
- `err_len` output 1: one-cycle pulse, LEN byte was 0 or greater than `MAX_LEN`.
- `err_csum` output 1: one-cycle pulse, checksum mismatch.
- `err_timeout` output 1: one-cycle pulse, inter-byte timeout inside a frame.
- `overrun` output 1: one-cycle pulse, a byte arrived while a frame was held and was dropped.

## Operation
- Byte strobe: `byte_stb = donerx & ~donerx_q`, where `donerx_q` is `donerx` registered (reset 0).
  - Exactly one strobe is produced per receiver byte, however long `donerx` stays high.
  - All processing below occurs only on cycles with `byte_stb` = 1.
- FSM states: IDLE, LEN, PAYLOAD, CSUM, HOLD. Reset state is IDLE.
- IDLE:
  - Byte == `SOF` goes to LEN.
  - Any other byte is ignored; no error is raised.
- LEN:
  - Byte of 0 or greater than `MAX_LEN`: pulse `err_len`, go to IDLE.
  - Otherwise: store the byte as the length, set `csum` to the byte, clear `idx`, go to PAYLOAD.
- PAYLOAD:
  - Each byte does `buffer[idx] <= byte`, `csum <= csum + byte` (mod 256), `idx <= idx + 1`.
  - After the byte where `idx` == length-1, go to CSUM.
- CSUM:
  - Byte == `csum`: load `frame_len`, go to HOLD.
  - Otherwise: pulse `err_csum`, go to IDLE.
- HOLD:
  - `frame_valid` = 1 and the buffer is frozen.
  - Any byte that arrives pulses `overrun` and is dropped.
  - `frame_ack` = 1 goes to IDLE.
- Simultaneous `frame_ack` and `byte_stb` in HOLD:
  - The ack is honoured.
  - The byte is evaluated under IDLE rules in the same cycle, so an `SOF` byte goes straight to LEN.
  - No `overrun` pulse.
- Timeout counter:
  - Cleared on every `byte_stb` and whenever the state is IDLE or HOLD.
  - Increments each cycle in LEN, PAYLOAD or CSUM.
  - On reaching `TIMEOUT` without a strobe: pulse `err_timeout`, go to IDLE, discard the partial frame.
  - A strobe in the same cycle the count would reach `TIMEOUT` wins: the byte is processed and the counter clears.
- The buffer is a register array and is not cleared by reset; its contents are valid only while `frame_valid` = 1.
- `rd_data` is readable at any time, but its value is defined only during HOLD.
- Reset mid-frame or mid-HOLD:
  - Returns to IDLE next cycle and drops the frame.
  - The consumer sees `frame_valid` fall with no ack required.

## Timing
- Reset values:
  - `frame_valid`, `err_len`, `err_csum`, `err_timeout`, `overrun` = 0.
  - `frame_len` = 0 and `rd_data` = 8'h00.
- Strobe latency: `donerx` rising at cycle N gives `byte_stb` at cycle N; state or register updates are visible at N+1.
- `frame_valid` rises 1 cycle after the strobe of a good checksum byte and stays high until the cycle after `frame_ack`.
- Error pulses assert 1 cycle after the offending strobe or timeout, for exactly 1 cycle.
- `rd_data` reflects `rd_addr` from the previous cycle.
- Minimum frame duration is 4 bytes (LEN=1). No throughput limit applies beyond receiver byte rate.

## Test plan
- Good frame:
  - Stimulus: A5, 03, 11, 22, 33, 69.
  - Required: `frame_valid` = 1, `frame_len` = 3.
  - Reads at addresses 0/1/2 return 11/22/33 one cycle later; `frame_ack` drops `frame_valid` next cycle.
- Checksum error:
  - Stimulus: A5, 02, 10, 20, 33 (expected checksum 32).
  - Required: one `err_csum` pulse, `frame_valid` stays 0, FSM back in IDLE.
  - A subsequent good frame is accepted.
- Length errors:
  - Stimulus: A5, 00, and separately A5, 11 with `MAX_LEN` = 16.
  - Required: an `err_len` pulse for each; following bytes are ignored until the next A5.
- Timeout:
  - Stimulus: A5, 02, 10, then silence for `TIMEOUT`+5 cycles.
  - Required: exactly one `err_timeout` pulse, `TIMEOUT` cycles after the last strobe.
  - Late bytes 20, 32 do not produce a frame.
- Overrun and simultaneous ack:
  - Stimulus: hold a good frame, send byte 55.
  - Required: `overrun` pulse; buffer contents unchanged.
  - Then assert `frame_ack` in the same cycle as an A5 strobe: no `overrun`, and the FSM enters LEN.
- Long `donerx` and reset:
  - Stimulus: hold `donerx` high for 50 cycles per byte.
  - Required: one byte is consumed per assertion.
  - Assert `rst` during PAYLOAD: all outputs return to reset values next cycle, and the next frame is received correctly.
